// File: rtl/gtxe2_chnl_tx_comma_ins.sv
// rtl/gtxe2_chnl_tx_comma_ins.sv - TX lane comma burst inserter with running-disparity tracking
module gtxe2_chnl_tx_comma_ins #(
  parameter int         width              = 20,
  parameter logic [9:0] ALIGN_PCOMMA_VALUE = 10'b0101111100,
  parameter logic [9:0] ALIGN_MCOMMA_VALUE = 10'b1010000011,
  parameter int         COMMA_PERIOD       = 256,
  parameter int         BURST_LEN          = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] indata,
  input  logic             invalid,
  output logic             inready,
  input  logic             txelecidle,
  input  logic             TXCOMMAFORCE,
  output logic [width-1:0] outdata,
  output logic             outelecidle,
  output logic             TXCOMMASENT,
  output logic             TXDISPERR
);

  typedef enum logic [1:0] {IDLE, BURST, DATA} state_t;

  localparam logic [7:0]  BURST_LAST  = 8'(BURST_LEN - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(COMMA_PERIOD - 1);

  state_t             state, state_nx;
  logic               rd, rd_nx;
  logic [7:0]         burst_cnt, burst_cnt_nx;
  logic [15:0]        period_cnt, period_cnt_nx;
  logic [width-1:0]   outdata_nx;
  logic               outelecidle_nx;
  logic               sent_nx;
  logic               disperr_nx;
  logic [width-1:0]   comma_word;
  logic [1:0]         sym0_res, sym1_res;

  // Number of ones in one 10-bit symbol.
  function automatic logic [3:0] ones10(input logic [9:0] s);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'b000, s[i]};
    end
    return n;
  endfunction

  // Disparity after one symbol; returns {weight_error, new_rd}.
  function automatic logic [1:0] step_rd(input logic rd_in, input logic [9:0] s);
    logic [3:0] w;
    w = ones10(s);
    if (w == 4'd6)      return {1'b0, 1'b1};
    else if (w == 4'd4) return {1'b0, 1'b0};
    else if (w == 4'd5) return {1'b0, rd_in};
    else                return {1'b1, rd_in};
  endfunction

  // Comma pair that keeps disparity balanced: lower symbol goes out first.
  assign comma_word = rd ? {ALIGN_PCOMMA_VALUE, ALIGN_MCOMMA_VALUE}
                         : {ALIGN_MCOMMA_VALUE, ALIGN_PCOMMA_VALUE};

  assign sym0_res = step_rd(rd, indata[9:0]);
  assign sym1_res = step_rd(sym0_res[0], indata[19:10]);

  assign inready = (state == DATA) & ~txelecidle & ~TXCOMMAFORCE & ~rst;

  // Next-state, counter and output-word selection for this cycle.
  always_comb begin
    state_nx       = state;
    rd_nx          = rd;
    burst_cnt_nx   = burst_cnt;
    period_cnt_nx  = period_cnt;
    outdata_nx     = '0;
    outelecidle_nx = 1'b1;
    sent_nx        = 1'b0;
    disperr_nx     = 1'b0;
    if (txelecidle) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nx     = BURST;
          burst_cnt_nx = '0;
        end
        BURST: begin
          outdata_nx     = comma_word;
          outelecidle_nx = 1'b0;
          if (TXCOMMAFORCE) begin
            burst_cnt_nx = '0;
          end else if (burst_cnt == BURST_LAST) begin
            sent_nx       = 1'b1;
            state_nx      = DATA;
            period_cnt_nx = '0;
            burst_cnt_nx  = '0;
          end else begin
            burst_cnt_nx = burst_cnt + 8'd1;
          end
        end
        DATA: begin
          outelecidle_nx = 1'b0;
          period_cnt_nx  = period_cnt + 16'd1;
          if (invalid && inready) begin
            outdata_nx = indata;
            rd_nx      = sym1_res[0];
            disperr_nx = sym0_res[1] | sym1_res[1];
          end else begin
            outdata_nx = comma_word;
          end
          if (TXCOMMAFORCE || period_cnt == PERIOD_LAST) begin
            state_nx     = BURST;
            burst_cnt_nx = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, disparity, counters and registered lane outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd          <= 1'b0;
      burst_cnt   <= '0;
      period_cnt  <= '0;
      outdata     <= '0;
      outelecidle <= 1'b1;
      TXCOMMASENT <= 1'b0;
      TXDISPERR   <= 1'b0;
    end else begin
      state       <= state_nx;
      rd          <= rd_nx;
      burst_cnt   <= burst_cnt_nx;
      period_cnt  <= period_cnt_nx;
      outdata     <= outdata_nx;
      outelecidle <= outelecidle_nx;
      TXCOMMASENT <= sent_nx;
      TXDISPERR   <= disperr_nx;
    end
  end

endmodule

// File: tb/tb_gtxe2_chnl_tx_comma_ins.sv
// tb/tb_gtxe2_chnl_tx_comma_ins.sv - scoreboard bench for the comma inserter
module tb_gtxe2_chnl_tx_comma_ins;

  localparam int         CP = 4;
  localparam int         BL = 2;
  localparam logic [9:0] PC = 10'b0101111100;
  localparam logic [9:0] MC = 10'b1010000011;

  typedef struct packed {
    logic [19:0] d;
    logic        ei;
    logic        sent;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] indata = '0;
  logic        invalid = 1'b0;
  logic        inready;
  logic        txelecidle = 1'b0;
  logic        comma_force = 1'b0;
  logic [19:0] outdata;
  logic        outelecidle;
  logic        comma_sent;
  logic        disp_err;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: mode 0 = idle, 1 = sending burst, 2 = data; countdowns of what remains.
  int   m_mode = 0;
  bit   m_rd = 1'b0;
  int   words_left = 0;
  int   slots_left = 0;

  always #5 clk = ~clk;

  gtxe2_chnl_tx_comma_ins #(
    .width(20), .ALIGN_PCOMMA_VALUE(PC), .ALIGN_MCOMMA_VALUE(MC),
    .COMMA_PERIOD(CP), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .indata(indata), .invalid(invalid), .inready(inready),
    .txelecidle(txelecidle), .TXCOMMAFORCE(comma_force), .outdata(outdata),
    .outelecidle(outelecidle), .TXCOMMASENT(comma_sent), .TXDISPERR(disp_err)
  );

  function automatic bit legal(input logic [9:0] s);
    int w;
    w = $countones(s);
    return (w >= 4 && w <= 6);
  endfunction

  function automatic bit next_rd(input bit r, input logic [9:0] s);
    int w;
    w = $countones(s);
    if (w == 6) return 1'b1;
    if (w == 4) return 1'b0;
    return r;
  endfunction

  function automatic logic [9:0] make_sym(input int w);
    logic [9:0] s;
    s = '0;
    while ($countones(s) < w) s[$urandom_range(0, 9)] = 1'b1;
    return s;
  endfunction

  function automatic logic [9:0] rand_sym();
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) return make_sym(3);
    if (k == 1) return make_sym(7);
    return make_sym(4 + (k % 3));
  endfunction

  // One clock of stimulus: drive, check inready, advance the model, queue the expected word.
  task automatic cyc(input bit r, input bit e, input bit f, input bit v, input logic [19:0] d);
    exp_t        x;
    bit          rdy;
    logic [19:0] comma;
    @(negedge clk);
    rst = r; txelecidle = e; comma_force = f; invalid = v; indata = d;
    rdy = !r && m_mode == 2 && !e && !f;
    #1;
    n_vec++;
    if (inready !== rdy) begin
      n_err++;
      $display("FAIL inready t=%0t: got %b want %b", $time, inready, rdy);
    end
    comma = m_rd ? {PC, MC} : {MC, PC};
    x = '0;
    x.ei = 1'b1;
    if (r) begin
      m_mode = 0; m_rd = 1'b0;
    end else if (e) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; words_left = BL;
    end else if (m_mode == 1) begin
      x.d = comma; x.ei = 1'b0;
      if (f) words_left = BL;
      else if (words_left == 1) begin
        x.sent = 1'b1; m_mode = 2; slots_left = CP;
      end else words_left--;
    end else begin
      x.ei = 1'b0;
      if (rdy && v) begin
        x.d   = d;
        x.err = !legal(d[9:0]) || !legal(d[19:10]);
        m_rd  = next_rd(next_rd(m_rd, d[9:0]), d[19:10]);
      end else begin
        x.d = comma;
      end
      if (f || slots_left == 1) begin
        m_mode = 1; words_left = BL;
      end else slots_left--;
    end
    sb.push_back(x);
  endtask

  // Monitor: every registered output word is compared against the queued prediction.
  always @(posedge clk) begin
    exp_t x, a;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      a = {outdata, outelecidle, comma_sent, disp_err};
      n_vec++;
      if (a !== x) begin
        n_err++;
        $display("FAIL lane_out t=%0t: got d=%h ei=%b sent=%b err=%b want d=%h ei=%b sent=%b err=%b",
                 $time, a.d, a.ei, a.sent, a.err, x.d, x.ei, x.sent, x.err);
      end
    end
  end

  initial begin
    logic [19:0] w;
    // reset, then first burst and idle fill
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, '0);
    // neutral words, then a word that flips RD positive, then idle fill
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, {make_sym(5), make_sym(5)});
    cyc(0, 0, 0, 1, {make_sym(5), make_sym(6)});
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, '0);
    // continuous data across several period expiries
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 1, {make_sym(5), make_sym(5)});
    // forced burst in data
    cyc(0, 0, 1, 1, {make_sym(5), make_sym(5)});
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, {make_sym(5), make_sym(5)});
    // elecidle on first burst word, then release
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, '0);
    // illegal-weight symbol
    w = {make_sym(5), make_sym(3)};
    cyc(0, 0, 0, 1, w);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, {rand_sym(), rand_sym()});
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7),
          {rand_sym(), rand_sym()});
    end
    @(posedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gtxe2_chnl_tx_comma_ins.md
GTXE2_CHNL_TX_COMMA_INS -- requirements
Module: gtxe2_chnl_tx_comma_ins

Interface
REQ-001 SHALL have parameter width, default 20, meaning lane word width, holding two 10-bit symbols; only 20 is supported.
REQ-002 SHALL have parameter ALIGN_PCOMMA_VALUE, default 10'b0101111100, meaning K28.5 RD- symbol, LSB transmitted first.
REQ-003 SHALL have parameter ALIGN_MCOMMA_VALUE, default 10'b1010000011, meaning K28.5 RD+ symbol, LSB transmitted first.
REQ-004 SHALL have parameter COMMA_PERIOD, default 256, meaning the number of DATA-state cycles between bursts; valid range 2..65535.
REQ-005 SHALL have parameter BURST_LEN, default 2, meaning the number of comma words per burst; valid range 1..255.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port indata, input, width bits: pre-encoded symbols; [9:0] is transmitted first, [19:10] second.
REQ-009 SHALL have port invalid, input, 1 bit: indata is valid.
REQ-010 SHALL have port inready, output, 1 bit: the block accepts indata this cycle.
REQ-011 SHALL have port txelecidle, input, 1 bit: request electrical idle.
REQ-012 SHALL have port TXCOMMAFORCE, input, 1 bit: request an immediate comma burst.
REQ-013 SHALL have port outdata, output, width bits: registered lane word.
REQ-014 SHALL have port outelecidle, output, 1 bit: registered; the lane is idle.
REQ-015 SHALL have port TXCOMMASENT, output, 1 bit: registered one-cycle pulse on the last word of a burst.
REQ-016 SHALL have port TXDISPERR, output, 1 bit: registered one-cycle pulse when an accepted symbol has illegal weight.

Function
REQ-017 SHALL implement an FSM with states IDLE, BURST and DATA, using a burst counter (8 bit) and a period counter (16 bit).
REQ-018 SHALL track the running disparity RD (0 = negative) across every transmitted symbol, in order: [9:0] first, then [19:10].
REQ-019 SHALL update RD per symbol by weight: 6 ones sets RD=1; 4 ones sets RD=0; 5 ones leaves RD unchanged; any other weight leaves RD unchanged and asserts TXDISPERR.
REQ-020 SHALL form a comma word as {ALIGN_MCOMMA_VALUE, ALIGN_PCOMMA_VALUE} when RD=0, or {ALIGN_PCOMMA_VALUE, ALIGN_MCOMMA_VALUE} when RD=1; a comma word leaves RD unchanged.
REQ-021 SHALL drive inready = (state==DATA) & ~txelecidle & ~TXCOMMAFORCE & ~rst, combinationally from registered state.
REQ-022 SHALL behave in IDLE as follows: outdata=0; outelecidle=1; RD is held; when txelecidle=0, next state is BURST with the burst counter reset to 0.
REQ-023 SHALL behave in BURST as follows: outdata=comma word; outelecidle=0; the burst counter increments each cycle; on count BURST_LEN-1, TXCOMMASENT=1, next state is DATA and the period counter is reset to 0.
REQ-024 SHALL, in DATA with invalid&inready, register outdata=indata with one-cycle latency and update RD.
REQ-025 SHALL, in DATA without an accepted word, send a comma word as idle fill.
REQ-026 SHALL, in DATA, increment the period counter every cycle; at COMMA_PERIOD-1 that cycle is still DATA and accepts data, then next state is BURST.
REQ-027 SHALL, when TXCOMMAFORCE=1 in DATA, send a comma word that cycle with inready=0; next state is BURST.
REQ-028 SHALL, when TXCOMMAFORCE=1 in BURST, restart the burst counter at 0.
REQ-029 SHALL start exactly one burst when force and period expiry coincide.
REQ-030 SHALL, when txelecidle=1 in any state, move to IDLE next cycle with inready=0 that cycle; an in-progress burst is aborted and TXCOMMASENT is not asserted.
REQ-031 SHALL give txelecidle priority over TXCOMMAFORCE.
REQ-032 SHALL always enter BURST on leaving IDLE, so no data word precedes a complete burst.
REQ-033 SHALL have outdata, outelecidle, TXCOMMASENT and TXDISPERR all registered.

Reset
REQ-034 SHALL, on rst=1 at a clock edge: state=IDLE, RD=0, both counters=0, outdata=0, outelecidle=1, TXCOMMASENT=0, TXDISPERR=0; inready is 0 while rst=1.
REQ-035 SHALL, on rst mid-burst or mid-data, discard everything in flight; no pulse is issued.

Verification
REQ-036 SHALL cover: reset, txelecidle=0, BURST_LEN=2 -> outelecidle=1 until the first word, then 2 words 0x283_17C, then TXCOMMASENT on the 2nd word, then inready=1.
REQ-037 SHALL cover: stream a neutral word (5+5 ones) with invalid=1 -> outdata equals indata one cycle later and RD stays 0; then a word whose [9:0] has 6 ones and [19:10] has 5 ones -> the next idle comma word is {PCOMMA, MCOMMA}.
REQ-038 SHALL cover: COMMA_PERIOD=4 with continuous data -> exactly 4 words accepted, then inready=0 for BURST_LEN cycles, then the pattern repeats.
REQ-039 SHALL cover: TXCOMMAFORCE for 1 cycle in DATA -> inready=0 that cycle, comma word, then a full burst, TXCOMMASENT, and the period counter restarted.
REQ-040 SHALL cover: txelecidle=1 on the first burst word -> IDLE next cycle, outdata=0, no TXCOMMASENT; on release -> a full burst.
REQ-041 SHALL cover: a symbol with 3 ones accepted -> TXDISPERR pulse for 1 cycle aligned with outdata, and RD unchanged.
